divider_seq: RTL and testbench
==============================

Name: divider_seq

Overview:
- Multi-cycle unsigned divider (DIVU), the inverse operation to the multiplier path.
- One restoring-division step per clock, using a WIDTH+1-bit subtract.
- Sits beside the ALU and is selected by the same 6-bit Signal operation code.
- Writes the quotient to LO and the remainder to HI.

Parameters:
WIDTH, 32, operand/result width in bits
DIVU_CODE, 6'd27, Signal value that selects the divide operation

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous active-low reset, sampled on the rising edge of clk
start  input  1  request pulse; qualified by Signal == DIVU_CODE
Signal  input  6  operation code
dataA  input  WIDTH  dividend
dataB  input  WIDTH  divisor
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when results become valid
div_zero  output  1  divisor was zero for the last accepted operation
quotient  output  WIDTH  LO result
remainder  output  WIDTH  HI result

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; busy=0, done=0, div_zero=0, quotient=0, remainder=0.
  - Internal counter and working registers are cleared.
  - Reset mid-operation aborts the divide and produces no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - Operation is accepted when start==1 and Signal==DIVU_CODE.
  - On accept: latch dataA into the quotient shift register and dataB into the divisor register.
  - Partial remainder=0, counter=WIDTH-1, div_zero=(dataB==0). Go to CALC.
  - start with any other Signal is ignored.
- CALC, one step per cycle:
  - r' = {rem[WIDTH-1:0], q[WIDTH-1]}; compute t = r' - {1'b0, divisor} at WIDTH+1 bits.
  - If t is non-negative (MSB 0): rem=t[WIDTH-1:0] and shift 1 into q LSB. Otherwise rem=r' and shift 0 into q.
  - Counter decrements each step. The step taken when counter==0 is the last one; then go to DONE.
  - busy=1 throughout CALC.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - quotient/remainder outputs update on entry to DONE.
  - Next state is IDLE, or CALC if a qualified start is present in the DONE cycle (back-to-back operation).
- Latency: a start accepted at edge N gives busy=1 from N through N+WIDTH-1.
  - done=1 in the cycle after edge N+WIDTH (32+1 cycles at default).
- Outputs quotient, remainder and div_zero hold their values until the next completed operation or reset. They do not change during CALC.
- start while in CALC is ignored; the operands are not re-latched.
- Divide by zero is not a special path. The restoring algorithm naturally yields quotient = all ones and remainder = dividend; div_zero=1 flags it.
- Operand changes on dataA/dataB after accept have no effect.

Decomposition:
- Shared package (with the ALU op codes): DIVU_CODE, the state encoding localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2), and WIDTH default.
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: rem, q_msb, divisor. Outputs: new rem, quotient bit.
  - Contains the WIDTH+1-bit subtractor.
- The top module holds the FSM, the counter (clog2(WIDTH) bits) and the registers.

Test Plan:
- Reset, then start with Signal=27, dataA=100, dataB=7 -> busy high for 32 cycles; done pulses at cycle 33; quotient=14, remainder=2, div_zero=0.
- dataA=32'hFFFFFFFF, dataB=1 -> quotient=32'hFFFFFFFF, remainder=0; then dataA=3, dataB=10 -> quotient=0, remainder=3.
- dataA=5, dataB=0 -> quotient=32'hFFFFFFFF, remainder=5, div_zero=1, same 33-cycle latency.
- start with Signal=6'd2 -> no busy, no done, outputs unchanged. start pulsed again at cycle 10 of a running divide -> ignored; the original result completes correctly.
- Drive reset=0 at cycle 15 of a divide -> next cycle busy=0, done=0, all outputs 0; no done pulse follows. A new divide (1000/10) then gives quotient=100, remainder=0.
- Qualified start held during the DONE cycle -> second divide (81/9 -> 9, 0) starts immediately; first results remain visible until the second done.

Source files
------------

// File: rtl/divider_seq_pkg.sv
// =============================================================================
// Module  : divider_seq_pkg
// Brief   : Shared ALU op codes, divider state encoding and width default.
// Revision: 1.0
// =============================================================================
`default_nettype none

package divider_seq_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [5:0] OP_DIVU = 6'd27;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/divider_seq_div_step.sv
// =============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division step (WIDTH+1-bit subtract).
// Revision: 1.0
// =============================================================================
`default_nettype none

module div_step
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, q_msb};
        diff    = shifted - {1'b0, divisor};
        // MSB clear means the trial subtraction did not underflow.
        q_bit   = ~diff[WIDTH];
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
        end else begin
            rem_next = shifted[WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/divider_seq.sv
// =============================================================================
// Module  : divider_seq
// Brief   : Multi-cycle unsigned divider (DIVU); quotient to LO, remainder to HI.
// Revision: 1.0
// =============================================================================
`default_nettype none

module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int         WIDTH     = WIDTH_DEFAULT,
    parameter logic [5:0] DIVU_CODE = OP_DIVU
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] q_q,         q_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic             dz_work_q,   dz_work_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q,  div_zero_d;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_q),
        .q_msb    (q_q[WIDTH-1]),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign accept = start && (Signal == DIVU_CODE);
    assign load   = accept && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            dz_work_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            dz_work_q   <= dz_work_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
    end

    // Datapath: operands latch only on accept; visible results move only on the last step.
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        dz_work_d   = dz_work_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        if (load) begin
            q_d       = dataA;
            divisor_d = dataB;
            rem_d     = '0;
            cnt_d     = CNT_W'(WIDTH - 1);
            dz_work_d = (dataB == '0);
        end else if (state_q == CALC) begin
            rem_d = step_rem;
            q_d   = {q_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                quotient_d  = {q_q[WIDTH-2:0], step_q};
                remainder_d = step_rem;
                div_zero_d  = dz_work_q;
            end
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_divider_seq.sv
// =============================================================================
// Module  : tb_divider_seq
// Brief   : Directed, scoreboard-driven bench for divider_seq.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_divider_seq;
    import divider_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   Signal;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    exp_t         last;
    int           errors = 0;
    int           checks = 0;

    divider_seq #(
        .WIDTH     (W),
        .DIVU_CODE (OP_DIVU)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Signal    (Signal),
        .dataA     (dataA),
        .dataB     (dataB),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a qualified start for one edge; scrambled operands afterwards must be ignored.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_result);
        exp_t e;
        start  = 1'b1;
        Signal = OP_DIVU;
        dataA  = a;
        dataB  = b;
        if (expect_result) begin
            e.q  = (b == '0) ? '1 : a / b;
            e.r  = (b == '0) ? a : a % b;
            e.dz = (b == '0);
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        dataA = $urandom;
        dataB = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int   cycles   = 0;
        int   busy_cnt = 0;
        exp_t e;
        while (done !== 1'b1 && cycles < 200) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, exp_cycles);
        check({tag, "_busy_cycles"}, busy_cnt, exp_cycles);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_quotient"},  quotient,  e.q);
            check({tag, "_remainder"}, remainder, e.r);
            check({tag, "_div_zero"},  div_zero,  e.dz);
            last = e;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        reset  = 1'b0;
        start  = 1'b0;
        Signal = 6'd0;
        dataA  = '0;
        dataB  = '0;
        last   = '0;
        repeat (2) tick();
        check("rst_busy",      busy,      0);
        check("rst_done",      done,      0);
        check("rst_quotient",  quotient,  0);
        check("rst_remainder", remainder, 0);
        check("rst_div_zero",  div_zero,  0);
        reset = 1'b1;
        tick();

        issue(32'd100, 32'd7, 1'b1);
        wait_done("d100_7", 32);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_busy",      busy, 0);

        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done("dmax_1", 32);
        tick();
        issue(32'd3, 32'd10, 1'b1);
        wait_done("d3_10", 32);
        tick();
        issue(32'd5, 32'd0, 1'b1);
        wait_done("d5_0", 32);
        tick();

        // Start with a non-divide op code must be ignored.
        start  = 1'b1;
        Signal = 6'd2;
        dataA  = 32'd9;
        dataB  = 32'd3;
        tick();
        start = 1'b0;
        check("other_op_busy", busy, 0);
        tick();
        check("other_op_done",     done,      0);
        check("other_op_quotient", quotient,  last.q);
        check("other_op_rem",      remainder, last.r);
        check("other_op_dz",       div_zero,  last.dz);

        // Restart mid-divide must not disturb the running operation.
        issue(32'd1234567, 32'd89, 1'b1);
        repeat (9) tick();
        start  = 1'b1;
        Signal = OP_DIVU;
        dataA  = 32'd77;
        dataB  = 32'd5;
        tick();
        start = 1'b0;
        check("hold_quotient_in_calc", quotient, last.q);
        check("hold_dz_in_calc",       div_zero, last.dz);
        wait_done("mid_start", 22);
        tick();

        // Reset in the middle of a divide aborts it.
        issue(32'd4000, 32'd3, 1'b0);
        repeat (13) tick();
        reset = 1'b0;
        tick();
        check("abort_busy",      busy,      0);
        check("abort_done",      done,      0);
        check("abort_quotient",  quotient,  0);
        check("abort_remainder", remainder, 0);
        check("abort_div_zero",  div_zero,  0);
        reset = 1'b1;
        seen  = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);

        issue(32'd1000, 32'd10, 1'b1);
        wait_done("d1000_10", 32);

        // Back-to-back: second start lands in the DONE cycle of the first.
        tick();
        issue(32'd200, 32'd7, 1'b1);
        wait_done("d200_7", 32);
        issue(32'd81, 32'd9, 1'b1);
        check("b2b_busy", busy, 1);
        repeat (5) tick();
        check("b2b_hold_quotient",  quotient,  last.q);
        check("b2b_hold_remainder", remainder, last.r);
        wait_done("d81_9", 27);
        tick();
        check("b2b_done_one_cycle", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
